hex_display_scanner: RTL and testbench
======================================

# hex_display_scanner

Time-multiplexed scan controller for a bank of common-anode seven-segment digits. Accepts a packed hex word through a valid/ready write port and double-buffers it so the display updates only at frame boundaries. Walks the digits in order with per-digit dead time and optional leading-zero suppression. Decodes the selected nibble into active-low segments using the team's existing hex-decoder encoding. Sits between the CPU's display register writes and the board's anode and segment pins.

## Interface
- DIGITS, 8, number of digits scanned; legal range 1..16.
- PRESCALE, 50000, clock cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 16, dead-time cycles at the start of each slot; may be 0.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; 0 turns the display dark.
- lz_en  in  1  leading-zero suppression enable.
- wr_valid  in  1  write request.
- wr_data  in  4*DIGITS  packed nibbles; digit i is wr_data[4i+3:4i], and digit 0 is rightmost/least significant.
- wr_ready  out  1  high when the pending buffer is empty.
- an_n  out  DIGITS  active-low anode enables; at most one bit is low at any time.
- seg_n  out  7  active-low segments a..g on bits 0..6.
- digit_idx  out  4  index of the current slot.
- frame_tick  out  1  one-cycle pulse at the end of each frame.

## Operation
- Storage:
  - A pending register and its full flag.
  - A display register.
  - A slot cycle counter, 0..PRESCALE-1.
  - A digit counter, 0..DIGITS-1.
- Write: a write is accepted when wr_valid and wr_ready are both high. wr_data goes to pending and the full flag sets.
- wr_ready equals the inverse of the full flag.
- Transfer pending→display:
  - In RUN: on the cycle that ends the last digit's slot.
  - In IDLE: on the cycle after the write is accepted.
  - On transfer the full flag clears.
- FSM states:
  - IDLE (en=0): an_n all 1, seg_n 7'h7F, both counters held at 0.
  - BLANK: slot cycles 0..BLANK_CYCLES-1. an_n all 1, seg_n 7'h7F.
  - SHOW: slot cycles BLANK_CYCLES..PRESCALE-1. an_n[digit] = 0 unless the digit is suppressed; seg_n carries the decoded nibble.
- FSM transitions:
  - BLANK→SHOW when the counter reaches BLANK_CYCLES-1. With BLANK_CYCLES=0 the FSM enters SHOW directly.
  - SHOW→BLANK of the next digit at counter PRESCALE-1. The digit counter wraps from DIGITS-1 to 0.
  - Any state→IDLE when en=0, effective the next cycle.
  - IDLE→BLANK of digit 0 when en=1.
- Suppression: digit i is dark (anode high, seg_n 7'h7F) when all of the following hold:
  - lz_en=1
  - i≠0
  - display nibbles i..DIGITS-1 are all zero
  - Digit 0 is always shown.
- Decode uses the existing active-low encoding (bit6..bit0):
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000
  - 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0010000, A→0001000, b→0000011
  - C→1000110, d→0100001, E→0000110, F→0001110
- digit_idx follows the digit counter in every state; it reads 0 in IDLE.

## Timing
- Reset values:
  - an_n all 1, seg_n 7'h7F, digit_idx 0, frame_tick 0, wr_ready 1.
  - Display register 0, pending empty, both counters 0.
  - FSM in IDLE; with en=1 it enters BLANK of digit 0 on the first edge after reset release.
- All outputs are registered.
- Frame length is DIGITS*PRESCALE cycles.
- frame_tick is high for exactly the one cycle after the final SHOW cycle of digit DIGITS-1. That is the same edge on which the transfer becomes visible.
- Tearing: new data first appears in the digit-0 slot of the frame after the transfer, never mid-frame.
- A write accepted on the same cycle as a frame end stays pending until the following frame end.
- Reset mid-frame: outputs go dark immediately (asynchronous). A pending write is discarded.
- en dropped mid-slot: the anode goes off on the next edge. When en returns, the scan restarts at digit 0 with BLANK.

## Test plan
All scenarios use DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
- Reset → wr_ready=1, an_n=4'hF, seg_n=7'h7F, digit_idx=0. After en=1: digit 0 shows 0 (seg_n=1000000) from slot cycle 2 to 7; the frame is 32 cycles long.
- Write 16'h1A3F in IDLE, then en=1 → slots 0..3 show F,3,A,1:
  - seg_n = 0001110, 0110000, 0001000, 1111001
  - an_n = 1110, 1101, 1011, 0111
  - Two dark cycles before each slot.
- While running, write 16'h0005 → wr_ready=0 until the frame end, then frame_tick pulses and wr_ready returns to 1. The next frame shows 5,0,0,0. With lz_en=1, only an_n[0] ever goes low.
- Second wr_valid while pending is full → it is not accepted. The displayed value after the frame end is the first write.
- en=0 during digit 2's SHOW phase → an_n=4'hF on the next edge. After en=1, the scan resumes at digit_idx=0 in BLANK.
- rst_n pulsed low mid-frame with a pending write → outputs go dark asynchronously, the display register reads 0, and wr_ready=1.

Source files
------------

// File: rtl/hex_display_scanner_if.sv
`timescale 1ns/1ps
// hex_display_scanner_if: valid/ready write port carrying one packed hex word
interface hex_display_scanner_if #(parameter int DIGITS = 8);
    logic                  wr_valid;
    logic [4*DIGITS-1:0]   wr_data;
    logic                  wr_ready;
    modport master(output wr_valid, wr_data, input wr_ready);
    modport slave(input wr_valid, wr_data, output wr_ready);
endinterface

// File: rtl/hex_display_scanner.sv
`timescale 1ns/1ps
// hex_display_scanner: multiplexed common-anode seven-segment scanner with a
// double-buffered hex word, per-slot dead time and leading-zero suppression
module hex_display_scanner #(
    parameter int DIGITS       = 8,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  lz_en,
    hex_display_scanner_if.slave  wr,
    output logic [DIGITS-1:0]     an_n,
    output logic [6:0]            seg_n,
    output logic [3:0]            digit_idx,
    output logic                  frame_tick
);
    localparam int CW = $clog2(PRESCALE + 1);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [3:0]          dig, dig_nx;
    logic [4*DIGITS-1:0] pend, disp, disp_nx;
    logic                full, slot_end, frame_end, xfer, z;
    logic [DIGITS-1:0]   zero_up, an_nx;
    logic [6:0]          seg_nx;

    assign wr.wr_ready = ~full;
    assign slot_end    = cnt == CW'(PRESCALE - 1);
    assign frame_end   = state != IDLE && slot_end && dig == 4'(DIGITS - 1);
    assign xfer        = full && (state == IDLE || frame_end);
    assign disp_nx     = xfer ? pend : disp;

    always_comb begin
        cnt_nx   = (!en || state == IDLE || slot_end) ? '0 : cnt + CW'(1);
        dig_nx   = (!en || state == IDLE) ? 4'd0 :
                   slot_end ? (dig == 4'(DIGITS - 1) ? 4'd0 : dig + 4'd1) : dig;
        state_nx = !en ? IDLE : (int'(cnt_nx) < BLANK_CYCLES ? BLANK : SHOW);
    end

    // Outputs are built from the next state so the registered pins line up with the FSM.
    always_comb begin
        z       = 1'b1;
        zero_up = '0;
        an_nx   = '1;
        seg_nx  = 7'h7F;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            z          = z && disp_nx[4*i +: 4] == 4'd0;
            zero_up[i] = z;
        end
        for (int i = 0; i < DIGITS; i++)
            if (state_nx == SHOW && 4'(i) == dig_nx && !(lz_en && i != 0 && zero_up[i])) begin
                an_nx[i] = 1'b0;
                seg_nx   = SEG_LUT[disp_nx[4*i +: 4]];
            end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dig        <= '0;
            pend       <= '0;
            disp       <= '0;
            full       <= 1'b0;
            an_n       <= '1;
            seg_n      <= 7'h7F;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            dig        <= dig_nx;
            disp       <= disp_nx;
            full       <= xfer ? 1'b0 : (full | wr.wr_valid);
            if (wr.wr_valid && !full)
                pend <= wr.wr_data;
            an_n       <= an_nx;
            seg_n      <= seg_nx;
            digit_idx  <= dig_nx;
            frame_tick <= frame_end;
        end
endmodule

// File: tb/tb_hex_display_scanner.sv
`timescale 1ns/1ps
// tb_hex_display_scanner: randomized scoreboard bench against a frame-time reference model
module tb_hex_display_scanner;
    localparam int D = 4, P = 8, B = 2, FRAME = D * P;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [3:0] idx;
        logic       ft;
        logic       rdy;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, lz_en = 1'b0;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic [3:0] digit_idx;
    logic       frame_tick;

    hex_display_scanner_if #(.DIGITS(D)) wif();

    hex_display_scanner #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .lz_en(lz_en), .wr(wif),
        .an_n(an_n), .seg_n(seg_n), .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] lut [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          checks = 0, errors = 0;
    exp_t        q[$];
    exp_t        mon_e, mon_a;
    bit          m_run = 0, m_full = 0;
    int          m_t = 0;
    logic [15:0] m_disp = '0, m_pend = '0;

    // Reference: position in the frame is a single cycle count since the scan started.
    task automatic model(input logic r, e, l, v, input logic [15:0] d);
        exp_t x;
        bit   fe, show;
        int   slot, ph;
        logic [3:0] nib;
        if (!r) begin
            m_run = 0; m_t = 0; m_disp = '0; m_pend = '0; m_full = 0;
            x = '{an: 4'hF, seg: 7'h7F, idx: 4'd0, ft: 1'b0, rdy: 1'b1};
        end else begin
            fe = m_run && m_t == FRAME - 1;
            if (m_full && (fe || !m_run)) begin
                m_disp = m_pend; m_full = 0;
            end else if (v && !m_full) begin
                m_pend = d; m_full = 1;
            end
            if (!e) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
            end else
                m_t = (m_t + 1) % FRAME;
            slot = m_t / P;
            ph   = m_t % P;
            nib  = 4'(m_disp >> (4 * slot));
            show = m_run && ph >= B && !(l && slot != 0 && (m_disp >> (4 * slot)) == 16'd0);
            x.an  = show ? ~(4'b1 << slot) : 4'hF;
            x.seg = show ? lut[nib] : 7'h7F;
            x.idx = 4'(slot);
            x.ft  = fe;
            x.rdy = !m_full;
        end
        q.push_back(x);
    endtask

    task automatic step(input logic r, e, l, v, input logic [15:0] d);
        @(negedge clk);
        rst_n = r; en = e; lz_en = l; wif.wr_valid = v; wif.wr_data = d;
        model(r, e, l, v, d);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (an_n !== 4'hF || seg_n !== 7'h7F || digit_idx !== 4'd0 || wif.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset an_n=%h seg_n=%h idx=%0d ready=%b required an_n=f seg_n=7f idx=0 ready=1",
                     an_n, seg_n, digit_idx, wif.wr_ready);
        end
        model(1'b0, en, lz_en, wif.wr_valid, wif.wr_data);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            mon_a = '{an: an_n, seg: seg_n, idx: digit_idx, ft: frame_tick, rdy: wif.wr_ready};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL outputs t=%0t an_n=%b/%b seg_n=%b/%b idx=%0d/%0d tick=%b/%b ready=%b/%b (actual/required)",
                         $time, mon_a.an, mon_e.an, mon_a.seg, mon_e.seg, mon_a.idx, mon_e.idx,
                         mon_a.ft, mon_e.ft, mon_a.rdy, mon_e.rdy);
            end
        end
    end

    initial begin
        logic        re, rl, rv;
        logic [15:0] rd;
        wif.wr_valid = 1'b0;
        wif.wr_data  = '0;
        repeat (3) step(0, 1, 0, 0, 16'h0);
        repeat (40) step(1, 1, 0, 0, 16'h0);
        repeat (3) step(1, 0, 0, 0, 16'h0);
        step(1, 0, 0, 1, 16'h1A3F);
        repeat (3) step(1, 0, 0, 0, 16'h0);
        repeat (70) step(1, 1, 0, 0, 16'h0);
        step(1, 1, 1, 1, 16'h0005);
        repeat (4) step(1, 1, 1, 1, 16'h9999);
        repeat (70) step(1, 1, 1, 0, 16'h0);
        repeat (3) step(1, 0, 0, 0, 16'h0);
        repeat (2 * P + B + 3) step(1, 1, 0, 0, 16'h0);
        repeat (3) step(1, 0, 0, 0, 16'h0);
        repeat (40) step(1, 1, 0, 0, 16'h0);
        step(1, 1, 0, 1, 16'h4321);
        repeat (3) step(1, 1, 0, 0, 16'h0);
        async_reset();
        repeat (2) step(0, 1, 0, 0, 16'h0);
        repeat (40) step(1, 1, 0, 0, 16'h0);
        re = 1'b1;
        rl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 63) == 0) re = ~re;
            if ($urandom_range(0, 31) == 0) rl = ~rl;
            rv = $urandom_range(0, 7) == 0;
            rd = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            if ($urandom_range(0, 399) == 0)
                async_reset();
            else
                step(1, re, rl, rv, rd);
        end
        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
